// File: rtl/dmi_jtag_dr.sv
// JTAG-side DTMCS/DMI data registers and the DMI request/response handshake.
// Optional response timeout enabled by defining DMI_JTAG_DR_TIMEOUT_EN.
module dmi_jtag_dr #(
  parameter int unsigned AbitsWidth    = 7,
  parameter int unsigned IdleCycles    = 1,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  dmi_clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  tdi_i,
  input  logic                  dtmcs_select_i,
  output logic                  dtmcs_tdo_o,
  input  logic                  dmi_select_i,
  output logic                  dmi_tdo_o,
  output logic                  dmi_rst_no,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [AbitsWidth-1:0] dmi_req_addr_o,
  output logic [1:0]            dmi_req_op_o,
  output logic [31:0]           dmi_req_data_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i
);

  localparam int unsigned DrW = AbitsWidth + 34;
  localparam logic [2:0]  IdleF  = 3'(IdleCycles);
  localparam logic [5:0]  AbitsF = 6'(AbitsWidth);

  typedef enum logic [2:0] {Idle, Read, WaitRead, Write, WaitWrite} state_e;

  state_e                state_q, state_d;
  logic [31:0]           dtmcs_q, dtmcs_d;
  logic [DrW-1:0]        dmi_q, dmi_d;
  logic [1:0]            error_q, error_d;
  logic [AbitsWidth-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rst_n_q, rst_n_d;
  logic                  hr_q, hr_d;
  logic                  clear, busy;
  logic [1:0]            dr_op;

`ifdef DMI_JTAG_DR_TIMEOUT_EN
  logic [31:0]           cnt_q, cnt_d;
`else
  logic                  unused_tmo;
  assign unused_tmo = (TimeoutCycles != 0);
`endif

  // hr_q marks the cycle dmi_rst_no is low after a hardreset; the clear lands at its end
  assign clear = dmi_clear_i | hr_q;
  assign busy  = (state_q != Idle);
  assign dr_op = dmi_q[1:0];

  always_comb begin
    state_d = state_q;
    dtmcs_d = dtmcs_q;
    dmi_d   = dmi_q;
    error_d = error_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rst_n_d = 1'b1;
    hr_d    = 1'b0;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      Read, Write: begin
        if (dmi_req_ready_i) begin
          state_d = (state_q == Read) ? WaitRead : WaitWrite;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WaitRead, WaitWrite: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (state_q == WaitRead) rdata_d = dmi_resp_data_i;
          if (error_q == 2'd0) error_d = dmi_resp_resp_i;
        end
`ifdef DMI_JTAG_DR_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == TimeoutCycles) begin
            state_d = Idle;
            rst_n_d = 1'b0;
            if (error_q == 2'd0) error_d = 2'd2;
          end
        end
`endif
      end
      default: ;
    endcase

    if (dtmcs_select_i) begin
      if (capture_i) begin
        dtmcs_d = {14'b0, 2'b0, 1'b0, IdleF, error_q, AbitsF, 4'd1};
      end else if (update_i) begin
        if (dtmcs_q[16]) error_d = 2'd0;
        if (dtmcs_q[17]) begin
          rst_n_d = 1'b0;
          hr_d    = 1'b1;
        end
      end else if (shift_i) begin
        dtmcs_d = {tdi_i, dtmcs_q[31:1]};
      end
    end

    if (dmi_select_i) begin
      if (capture_i) begin
        dmi_d = {addr_q, rdata_q, busy ? 2'd3 : error_q};
        if (busy && error_d == 2'd0) error_d = 2'd3;
      end else if (update_i) begin
        if (error_q == 2'd0) begin
          if (busy) begin
            error_d = 2'd3;
          end else if (dr_op == 2'd1 || dr_op == 2'd2) begin
            addr_d  = dmi_q[DrW-1:34];
            wdata_d = dmi_q[33:2];
            state_d = (dr_op == 2'd1) ? Read : Write;
          end
        end
      end else if (shift_i) begin
        dmi_d = {tdi_i, dmi_q[DrW-1:1]};
      end
    end

    if (clear) begin
      state_d = Idle;
      dtmcs_d = '0;
      dmi_d   = '0;
      error_d = '0;
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
      rst_n_d = 1'b1;
      hr_d    = 1'b0;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      dtmcs_q <= '0;
      dmi_q   <= '0;
      error_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rst_n_q <= 1'b1;
      hr_q    <= 1'b0;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dtmcs_q <= dtmcs_d;
      dmi_q   <= dmi_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rst_n_q <= rst_n_d;
      hr_q    <= hr_d;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dmi_q[0];
  assign dmi_rst_no       = rst_n_q;
  // a pending clear kills the request in the same cycle, not one edge later
  assign dmi_req_valid_o  = ((state_q == Read) || (state_q == Write)) && !clear;
  assign dmi_req_op_o     = (state_q == Read) ? 2'd1 : (state_q == Write) ? 2'd2 : 2'd0;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = wdata_q;
  assign dmi_resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: DTMCS/DMI scans, request handshake, error, clears.
module tb_dmi_jtag_dr;
  localparam int AW = 7;

  logic          tck = 1'b0;
  logic          trst_n, dmi_clear, capture, shift, update, tdi;
  logic          dtmcs_sel, dtmcs_tdo, dmi_sel, dmi_tdo, dmi_rst_n;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_op, resp_resp;
  logic [31:0]   req_data, resp_data;
  logic [63:0]   dout;
  int            n_cmp = 0, n_err = 0;

  always #5 tck = ~tck;

  dmi_jtag_dr #(.AbitsWidth(AW), .IdleCycles(1), .TimeoutCycles(4)) dut (
    .tck_i(tck), .trst_ni(trst_n), .dmi_clear_i(dmi_clear),
    .capture_i(capture), .shift_i(shift), .update_i(update), .tdi_i(tdi),
    .dtmcs_select_i(dtmcs_sel), .dtmcs_tdo_o(dtmcs_tdo),
    .dmi_select_i(dmi_sel), .dmi_tdo_o(dmi_tdo), .dmi_rst_no(dmi_rst_n),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge tck);
  endtask

  // Full Capture/Shift/Update pass; dout collects TDO bits in shift order.
  task automatic scan(input logic is_dmi, input logic [63:0] din, input int len,
                      output logic [63:0] d);
    d = '0;
    dtmcs_sel = !is_dmi; dmi_sel = is_dmi;
    capture = 1'b1; tick(); capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < len; i++) begin
      tdi  = din[i];
      d[i] = is_dmi ? dmi_tdo : dtmcs_tdo;
      tick();
    end
    shift = 1'b0; tdi = 1'b0;
    update = 1'b1; tick(); update = 1'b0;
    dtmcs_sel = 1'b0; dmi_sel = 1'b0;
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  task automatic accept();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    resp_valid = 1'b1; resp_data = d; resp_resp = r; tick();
    resp_valid = 1'b0; resp_data = '0; resp_resp = '0;
  endtask

  initial begin
    trst_n = 1'b0; dmi_clear = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; dtmcs_sel = 1'b0; dmi_sel = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; resp_resp = '0;
    #22;
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_rstn", 64'(dmi_rst_n), 64'd1);
    chk("rst_respready", 64'(resp_ready), 64'd1);
    chk("rst_op", 64'(req_op), 64'd0);
    chk("rst_tdo", 64'({dtmcs_tdo, dmi_tdo}), 64'd0);
    tick(); trst_n = 1'b1; tick();

    // DTMCS capture value
    scan(1'b0, 64'd0, 32, dout);
    chk("dtmcs_cap", dout[31:0], 64'h1071);

    // write request held until ready, then ok response
    scan(1'b1, dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, dout);
    chk("wr_valid", 64'(req_valid), 64'd1);
    chk("wr_addr", 64'(req_addr), 64'h10);
    chk("wr_op", 64'(req_op), 64'd2);
    chk("wr_data", 64'(req_data), 64'hDEADBEEF);
    tick(); tick();
    chk("wr_hold", 64'({req_valid, req_op}), 64'h6);
    accept();
    chk("wr_acc", 64'(req_valid), 64'd0);
    respond(32'h0, 2'd0);
    scan(1'b1, 64'd0, 41, dout);
    chk("wr_cap_op", 64'(dout[1:0]), 64'd0);
    chk("wr_cap_addr", 64'(dout[40:34]), 64'h10);

    // read returns data on next capture
    scan(1'b1, dmi_word(7'h11, 32'h0, 2'd1), 41, dout);
    chk("rd_req", 64'({req_valid, req_op, req_addr}), {55'b0, 1'b1, 2'd1, 7'h11});
    accept();
    respond(32'h12345678, 2'd0);
    scan(1'b1, 64'd0, 41, dout);
    chk("rd_data", 64'(dout[33:2]), 64'h12345678);
    chk("rd_op", 64'(dout[1:0]), 64'd0);

    // capture while busy -> busy error, sticky until dmireset
    scan(1'b1, dmi_word(7'h05, 32'h0, 2'd1), 41, dout);
    accept();
    scan(1'b1, dmi_word(7'h05, 32'h1, 2'd2), 41, dout);
    chk("busy_cap_op", 64'(dout[1:0]), 64'd3);
    chk("busy_noreq", 64'(req_valid), 64'd0);
    respond(32'hAAAA5555, 2'd0);
    scan(1'b1, dmi_word(7'h06, 32'h2, 2'd2), 41, dout);
    chk("sticky_op", 64'(dout[1:0]), 64'd3);
    chk("sticky_noreq", 64'(req_valid), 64'd0);
    scan(1'b0, 64'h1_0000, 32, dout);
    chk("dtmcs_err", dout[31:0], 64'h1C71);
    scan(1'b1, dmi_word(7'h22, 32'h0, 2'd1), 41, dout);
    chk("after_rst_req", 64'({req_valid, req_op, req_addr}), {55'b0, 1'b1, 2'd1, 7'h22});
    accept();
    respond(32'h0, 2'd0);

    // dmi_clear drops a pending request combinationally and clears error
    scan(1'b1, dmi_word(7'h33, 32'h5, 2'd2), 41, dout);
    scan(1'b1, 64'd0, 41, dout);
    chk("clr_busy_op", 64'(dout[1:0]), 64'd3);
    chk("clr_pre_valid", 64'(req_valid), 64'd1);
    dmi_clear = 1'b1; #1;
    chk("clr_same_cycle", 64'(req_valid), 64'd0);
    tick(); dmi_clear = 1'b0;
    chk("clr_valid", 64'(req_valid), 64'd0);
    scan(1'b0, 64'd0, 32, dout);
    chk("clr_err", dout[31:0], 64'h1071);

    // dmihardreset: one-cycle dmi_rst_no low, then full clear
    scan(1'b1, dmi_word(7'h44, 32'h0, 2'd1), 41, dout);
    scan(1'b0, 64'h2_0000, 32, dout);
    chk("hr_rstn_low", 64'({dmi_rst_n, req_valid}), 64'd0);
    tick();
    chk("hr_rstn_high", 64'({dmi_rst_n, req_valid}), 64'h2);
    scan(1'b1, 64'd0, 41, dout);
    chk("hr_cleared", dout[40:0], 64'd0);

    // asynchronous trst mid-shift
    scan(1'b1, dmi_word(7'h55, 32'h7, 2'd2), 41, dout);
    dtmcs_sel = 1'b1; capture = 1'b1; tick(); capture = 1'b0;
    chk("pre_trst_tdo", 64'(dtmcs_tdo), 64'd1);
    shift = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_trst_bit4", 64'({dtmcs_tdo, req_valid}), 64'h3);
    #2 trst_n = 1'b0; #1;
    chk("trst_outs", 64'({dtmcs_tdo, dmi_tdo, req_valid, dmi_rst_n, resp_ready}), 64'h3);
    shift = 1'b0; dtmcs_sel = 1'b0;
    tick(); trst_n = 1'b1; tick();

`ifdef DMI_JTAG_DR_TIMEOUT_EN
    // no response: timeout after 4 cycles in WaitRead
    scan(1'b1, dmi_word(7'h66, 32'h0, 2'd1), 41, dout);
    accept();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_wait", 64'(dmi_rst_n), 64'd1);
    end
    tick();
    chk("tmo_pulse", 64'({dmi_rst_n, req_valid}), 64'd0);
    respond(32'hCAFEF00D, 2'd3);
    chk("tmo_pulse_end", 64'(dmi_rst_n), 64'd1);
    scan(1'b1, 64'd0, 41, dout);
    chk("tmo_err", 64'(dout[1:0]), 64'd2);
    chk("tmo_late_ignored", 64'(dout[33:2]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmi_jtag_dr.md
Name: dmi_jtag_dr

Overview:
- JTAG-domain data-register logic directly downstream of the DMI TAP / BSCANE2 wrapper.
- Consumes the TAP's capture/shift/update/select/tdi strobes, implements the DTMCS and DMI data registers, and returns their serial TDO bits.
- Converts completed DMI DR updates into a valid/ready request toward the DMI clock-domain crossing, and collects the response.
- Keeps the sticky dmistat error state.

Parameters:
- AbitsWidth, 7, DMI address width; DMI DR width = AbitsWidth+34.
- IdleCycles, 1, value reported in DTMCS.idle[14:12].
- TimeoutCycles, 255, tck cycles to wait for a response (used only with the optional feature).

Ports:
- tck_i  in  1  JTAG clock (TAP tck_o)
- trst_ni  in  1  async active-low reset
- dmi_clear_i  in  1  sync clear (TAP Test-Logic-Reset)
- capture_i  in  1  Capture-DR strobe
- shift_i  in  1  Shift-DR strobe
- update_i  in  1  Update-DR strobe
- tdi_i  in  1  serial data in
- dtmcs_select_i  in  1  DTMCS DR selected
- dtmcs_tdo_o  out  1  DTMCS serial out
- dmi_select_i  in  1  DMI DR selected
- dmi_tdo_o  out  1  DMI serial out
- dmi_rst_no  out  1  active-low DMI reset pulse toward CDC
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request accepted
- dmi_req_addr_o  out  AbitsWidth  request address
- dmi_req_op_o  out  2  1=read, 2=write
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  response ready
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- Clocking/reset: single clock tck_i, posedge. Reset trst_ni is asynchronous, active-low.
- Reset values: all registers 0, state Idle, error=0, dmi_rst_no=1, dmi_req_valid_o=0, dmi_resp_ready_o=1.
- Serial outputs: dtmcs_tdo_o = dtmcs_sr[0]; dmi_tdo_o = dmi_sr[0]; both combinational from the register LSB. Negedge TDO retiming is the TAP's responsibility.
- DTMCS (32b):
  - Capture with dtmcs_select_i loads {14'b0, 2'b0, 1'b0, IdleCycles[2:0], error[1:0], AbitsWidth[5:0], 4'd1}.
  - Shift: sr <= {tdi_i, sr[31:1]}.
  - Update:
    - bit16 (dmireset) clears error.
    - bit17 (dmihardreset) drives dmi_rst_no low for exactly 1 cycle, then performs the full clear described below.
- DMI DR layout: [AbitsWidth+33:34] addr, [33:2] data, [1:0] op.
  - Capture with dmi_select_i loads {addr_q, rdata_q, error}.
  - If state != Idle at capture: error <= 3 (busy) unless error is already nonzero; the captured op field shows 3.
  - Shift is the same LSB-first rule as DTMCS.
- Update with dmi_select_i, error==0:
  - op=1 -> Read; op=2 -> Write; op=0/3 -> no action.
  - addr_q and wdata latched from the DR.
  - If update arrives while state != Idle: error <= 3, and the request is dropped.
- FSM:
  - Idle -> Read/Write on a qualifying update.
  - Read/Write: dmi_req_valid_o=1, outputs stable. Move to WaitRead/WaitWrite in the cycle dmi_req_ready_i=1.
  - WaitRead/WaitWrite: on dmi_resp_valid_i, go to Idle.
    - WaitRead latches rdata_q <= dmi_resp_data_i.
    - If resp != 0, error <= resp; an existing nonzero error is kept.
- dmi_resp_ready_o = 1 in every state. A response arriving in Idle is consumed and ignored.
- Sticky error: cleared only by dmireset, dmihardreset, dmi_clear_i or trst_ni.
- dmi_clear_i / hardreset (synchronous, highest priority over all strobes):
  - State -> Idle, error/addr_q/rdata_q/shift registers -> 0, dmi_req_valid_o dropped the same cycle.
- Strobe priority: capture, shift and update are mutually exclusive. If more than one is asserted, capture > update > shift. With neither select asserted, no register changes.

Optional Feature:
- Macro DMI_JTAG_DR_TIMEOUT_EN.
- Defined:
  - A counter runs in WaitRead/WaitWrite, cleared on entry.
  - When the counter reaches TimeoutCycles without a response: state -> Idle, error <= 2 if error==0, and dmi_rst_no pulses low 1 cycle to flush the CDC.
  - A late response is then absorbed and ignored.
- Undefined: no counter; the block waits indefinitely; TimeoutCycles is unused.

Test Plan:
- DTMCS capture, AbitsWidth=7, IdleCycles=1, error=0 -> 32 shifted bits = 0x00001071.
- DMI write addr=0x10, data=0xDEADBEEF, op=2 -> req_valid with addr 0x10/op 2/data 0xDEADBEEF, held until ready; resp ok -> next capture op field = 0.
- DMI read addr=0x11, resp data 0x12345678, resp 0 -> next capture shifts out data 0x12345678, op 0.
- Capture while in WaitRead -> op field = 3. Subsequent update with op=2 issues no request. DTMCS update with bit16=1 -> error=0, next op=1 is accepted.
- dmi_clear_i asserted while dmi_req_valid_o=1 -> valid low the same cycle, state Idle, error 0. trst_ni low mid-shift -> all outputs return to reset values asynchronously.
- With DMI_JTAG_DR_TIMEOUT_EN, TimeoutCycles=4, no response -> after 4 cycles: Idle, error=2, one-cycle dmi_rst_no low. A response arriving afterwards is ignored.
